updi_line_ctrl: RTL and testbench

Sequencer and owner of the single-wire UPDI TX line. Shares the line between the double-break generator and the byte UART transmitter. Issues the break sequence on request, enforces a guard time after the break, then grants byte transmissions. Tracks link state and detects requester handshakes that never respond. Sits between the UPDI protocol engine above and the break/UART PHY blocks below.

---
 rtl/updi_line_ctrl_if.sv | 23 ++
 rtl/updi_line_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_updi_line_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/updi_line_ctrl_if.sv
// Protocol-engine side of the UPDI line controller: break request/status and byte handshake.
interface updi_line_ctrl_if;
  logic       brk_req;
  logic       brk_done;
  logic       link_drop;
  logic       link_up;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       err;
  logic       busy;

  modport master (
    output brk_req, link_drop, tx_valid, tx_data,
    input  brk_done, link_up, tx_ready, tx_done, err, busy
  );

  modport slave (
    input  brk_req, link_drop, tx_valid, tx_data,
    output brk_done, link_up, tx_ready, tx_done, err, busy
  );
endinterface

// File: rtl/updi_line_ctrl.sv
// UPDI TX line owner: sequences double-break, post-break guard time and byte transmissions.
// Optional macro UPDI_LINE_CTRL_AUTO_BREAK_EN: a byte request while the link is down triggers a break.
module updi_line_ctrl #(
  parameter int GUARD_CLK   = 32,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  updi_line_ctrl_if.slave    host,
  output logic               brk_start,
  input  logic               brk_busy,
  input  logic               brk_line,
  output logic               uart_start,
  output logic [7:0]         uart_data,
  input  logic               uart_busy,
  input  logic               uart_line,
  output logic               updi_tx,
  output logic               updi_oe
);

  localparam int CNT_MAX = (GUARD_CLK > ACK_TIMEOUT) ? GUARD_CLK : ACK_TIMEOUT;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CLK > 0) ? GUARD_CLK - 1 : 0);
  localparam logic [CW-1:0] ACK_LAST   = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BRK_START = 3'd1,
    ST_BRK_WAIT  = 3'd2,
    ST_GUARD     = 3'd3,
    ST_TX_START  = 3'd4,
    ST_TX_WAIT   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic          seen_q, seen_d;
  logic          pending_q, pending_d;
  logic          link_up_q, link_up_d;
  logic [7:0]    uart_data_q, uart_data_d;
  logic          brk_done_q, brk_done_d;
  logic          tx_done_q, tx_done_d;
  logic          err_q, err_d;
  logic          brk_start_q, uart_start_q, busy_q, updi_oe_q, updi_tx_q;
  logic          line_d_s, link_set_s, tx_ready_s, auto_brk_s, phy_busy_s;

  // Next-state, counter, link and pending-flag logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seen_d      = seen_q;
    uart_data_d = uart_data_q;
    brk_done_d  = 1'b0;
    tx_done_d   = 1'b0;
    err_d       = 1'b0;
    link_set_s  = 1'b0;
    tx_ready_s  = 1'b0;
    auto_brk_s  = 1'b0;
    phy_busy_s  = (state_q == ST_BRK_WAIT) ? brk_busy : uart_busy;
    cnt_inc_s   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d = ST_BRK_START;
        end else begin
          tx_ready_s = link_up_q && !host.brk_req;
          if (tx_ready_s && host.tx_valid) begin
            uart_data_d = host.tx_data;
            state_d     = ST_TX_START;
          end else begin
`ifdef UPDI_LINE_CTRL_AUTO_BREAK_EN
            auto_brk_s = !link_up_q && host.tx_valid;
`else
            auto_brk_s = 1'b0;
`endif
          end
        end
      end
      ST_BRK_START, ST_TX_START: begin
        cnt_d   = '0;
        seen_d  = 1'b0;
        state_d = (state_q == ST_BRK_START) ? ST_BRK_WAIT : ST_TX_WAIT;
      end
      // Shared PHY handshake: wait for busy to rise (bounded), then for it to fall
      ST_BRK_WAIT, ST_TX_WAIT: begin
        if (!seen_q) begin
          if (phy_busy_s) begin
            seen_d = 1'b1;
          end else if (cnt_q == ACK_LAST) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else if (!phy_busy_s) begin
          if (state_q == ST_TX_WAIT) begin
            tx_done_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (GUARD_CLK == 0) begin
            brk_done_d = 1'b1;
            link_set_s = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_GUARD;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          brk_done_d = 1'b1;
          link_set_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Break completion re-establishes the link even if it was dropped during the guard
    if (link_set_s) begin
      link_up_d = 1'b1;
    end else if (err_d || host.link_drop) begin
      link_up_d = 1'b0;
    end else begin
      link_up_d = link_up_q;
    end

    if (host.brk_req || auto_brk_s) begin
      pending_d = 1'b1;
    end else if ((state_q == ST_IDLE) && (state_d == ST_BRK_START)) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    case (state_d)
      ST_BRK_START, ST_BRK_WAIT: line_d_s = brk_line;
      ST_TX_START, ST_TX_WAIT:   line_d_s = uart_line;
      default:                   line_d_s = 1'b1;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      seen_q       <= 1'b0;
      pending_q    <= 1'b0;
      link_up_q    <= 1'b0;
      uart_data_q  <= 8'h00;
      brk_done_q   <= 1'b0;
      tx_done_q    <= 1'b0;
      err_q        <= 1'b0;
      brk_start_q  <= 1'b0;
      uart_start_q <= 1'b0;
      busy_q       <= 1'b0;
      updi_oe_q    <= 1'b0;
      updi_tx_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      pending_q    <= pending_d;
      link_up_q    <= link_up_d;
      uart_data_q  <= uart_data_d;
      brk_done_q   <= brk_done_d;
      tx_done_q    <= tx_done_d;
      err_q        <= err_d;
      brk_start_q  <= (state_d == ST_BRK_START);
      uart_start_q <= (state_d == ST_TX_START);
      busy_q       <= (state_d != ST_IDLE);
      updi_oe_q    <= (state_d != ST_IDLE);
      updi_tx_q    <= line_d_s;
    end
  end

  assign host.tx_ready = tx_ready_s;
  assign host.brk_done = brk_done_q;
  assign host.link_up  = link_up_q;
  assign host.tx_done  = tx_done_q;
  assign host.err      = err_q;
  assign host.busy     = busy_q;
  assign brk_start     = brk_start_q;
  assign uart_start    = uart_start_q;
  assign uart_data     = uart_data_q;
  assign updi_tx       = updi_tx_q;
  assign updi_oe       = updi_oe_q;

endmodule

// File: tb/tb_updi_line_ctrl.sv
// Self-checking bench for updi_line_ctrl with behavioural break/UART PHY models and a byte scoreboard.
module tb_updi_line_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       brk_start, brk_busy, brk_line;
  logic       uart_start, uart_busy, uart_line;
  logic [7:0] uart_data;
  logic       updi_tx, updi_oe;

  int tests_run = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  int brk_len = 300;
  int uart_len = 10;
  bit brk_respond = 1'b1;
  int brk_cnt, uart_cnt;

  updi_line_ctrl_if host_if ();

  updi_line_ctrl #(.GUARD_CLK(32), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .host(host_if),
    .brk_start(brk_start), .brk_busy(brk_busy), .brk_line(brk_line),
    .uart_start(uart_start), .uart_data(uart_data), .uart_busy(uart_busy), .uart_line(uart_line),
    .updi_tx(updi_tx), .updi_oe(updi_oe)
  );

  always #5 clk = ~clk;

  // Break generator model: busy for brk_len clocks after a start pulse, line low while busy
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_busy <= 1'b0; brk_cnt <= 0;
    end else if (brk_start && brk_respond) begin
      brk_busy <= 1'b1; brk_cnt <= brk_len;
    end else if (brk_cnt > 1) begin
      brk_cnt <= brk_cnt - 1;
    end else begin
      brk_busy <= 1'b0; brk_cnt <= 0;
    end
  end
  assign brk_line = ~brk_busy;

  // UART model: busy for uart_len clocks after a start pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_busy <= 1'b0; uart_cnt <= 0;
    end else if (uart_start) begin
      uart_busy <= 1'b1; uart_cnt <= uart_len;
    end else if (uart_cnt > 1) begin
      uart_cnt <= uart_cnt - 1;
    end else begin
      uart_busy <= 1'b0; uart_cnt <= 0;
    end
  end
  assign uart_line = ~uart_busy;

  task automatic test_reset;
    logic [9:0] v;
    host_if.brk_req = 1'b0; host_if.link_drop = 1'b0; host_if.tx_valid = 1'b0; host_if.tx_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    v = {host_if.busy, host_if.link_up, host_if.tx_ready, updi_tx, updi_oe, brk_start, uart_start,
         host_if.brk_done, host_if.tx_done, host_if.err};
    tests_run++;
    if (v !== 10'b0001000000) begin fails++; $display("FAIL reset_outputs: got %b expected %b", v, 10'b0001000000); end
    tests_run++;
    if (uart_data !== 8'h00) begin fails++; $display("FAIL reset_uart_data: got %h expected 00", uart_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    v = {host_if.busy, host_if.link_up, host_if.tx_ready, updi_tx, updi_oe, brk_start, uart_start,
         host_if.brk_done, host_if.tx_done, host_if.err};
    tests_run++;
    if (v !== 10'b0001000000) begin fails++; $display("FAIL idle_after_reset: got %b expected %b", v, 10'b0001000000); end
  endtask

  task automatic test_break;
    int k, done_at, bad;
    bit ended;
    brk_len = 300;
    @(negedge clk); host_if.brk_req = 1'b1;
    @(negedge clk); host_if.brk_req = 1'b0;
    tests_run++;
    if (brk_start !== 1'b0) begin fails++; $display("FAIL brk_start_early: got %b expected 0", brk_start); end
    @(negedge clk);
    tests_run++;
    if ({brk_start, host_if.busy, updi_oe} !== 3'b111) begin
      fails++; $display("FAIL brk_start_pulse: got %b expected 111", {brk_start, host_if.busy, updi_oe});
    end
    @(negedge clk);
    tests_run++;
    if (brk_start !== 1'b0) begin fails++; $display("FAIL brk_start_width: got %b expected 0", brk_start); end
    k = 0; ended = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (brk_busy) begin
        k++;
        if (k == 5) begin
          tests_run++;
          if ({updi_tx, updi_oe} !== 2'b01) begin
            fails++; $display("FAIL line_follows_brk: got %b expected 01", {updi_tx, updi_oe});
          end
        end
      end else if (k > 0) begin
        ended = 1'b1; break;
      end
    end
    tests_run++;
    if (!ended) begin fails++; $display("FAIL break_end_timeout: got %0d busy cycles, expected busy to fall", k); end
    done_at = 0; bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (host_if.brk_done) begin done_at = n; break; end
      else if (!(updi_tx === 1'b1 && updi_oe === 1'b1)) bad++;
    end
    tests_run++;
    if (done_at != 33) begin fails++; $display("FAIL guard_length: got brk_done at %0d expected 33", done_at); end
    tests_run++;
    if (bad != 0) begin fails++; $display("FAIL guard_line_high: got %0d bad cycles expected 0", bad); end
    tests_run++;
    if (host_if.link_up !== 1'b1) begin fails++; $display("FAIL link_up_after_break: got %b expected 1", host_if.link_up); end
    @(negedge clk);
    tests_run++;
    if ({host_if.brk_done, host_if.busy} !== 2'b00) begin
      fails++; $display("FAIL brk_done_width: got %b expected 00", {host_if.brk_done, host_if.busy});
    end
  endtask

  task automatic test_tx_byte;
    bit got, done, chk;
    logic [7:0] exp;
    uart_len = 10;
    @(negedge clk);
    tests_run++;
    if (host_if.tx_ready !== 1'b1) begin fails++; $display("FAIL tx_ready_idle: got %b expected 1", host_if.tx_ready); end
    host_if.tx_valid = 1'b1; host_if.tx_data = 8'h55; exp_q.push_back(8'h55);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_start) begin got = 1'b1; break; end
    end
    host_if.tx_valid = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    tests_run++;
    if (!got || uart_data !== exp) begin fails++; $display("FAIL tx_uart_data: got %h (start %b) expected %h", uart_data, got, exp); end
    done = 1'b0; chk = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_busy && !chk) begin
        chk = 1'b1; tests_run++;
        if (uart_data !== exp) begin fails++; $display("FAIL tx_data_stable: got %h expected %h", uart_data, exp); end
      end
      if (host_if.tx_done) begin done = 1'b1; break; end
    end
    tests_run++;
    if (!done || host_if.busy !== 1'b0) begin fails++; $display("FAIL tx_done_busy: done %b busy %b expected done 1 busy 0", done, host_if.busy); end
    @(negedge clk);
    tests_run++;
    if ({host_if.tx_done, host_if.busy} !== 2'b00) begin
      fails++; $display("FAIL tx_after_done: got %b expected 00", {host_if.tx_done, host_if.busy});
    end
  endtask

  task automatic test_brk_tx_same_cycle;
    bit saw_done, got, done;
    logic [7:0] exp;
    brk_len = 20;
    @(negedge clk);
    host_if.brk_req = 1'b1; host_if.tx_valid = 1'b1; host_if.tx_data = 8'hA3; exp_q.push_back(8'hA3);
    #1;
    tests_run++;
    if (host_if.tx_ready !== 1'b0) begin fails++; $display("FAIL same_cycle_tx_ready: got %b expected 0", host_if.tx_ready); end
    saw_done = 1'b0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      host_if.brk_req = 1'b0;
      if (host_if.brk_done) saw_done = 1'b1;
      if (uart_start) begin got = 1'b1; break; end
    end
    host_if.tx_valid = 1'b0;
    tests_run++;
    if ({got, saw_done} !== 2'b11) begin fails++; $display("FAIL break_before_byte: got start/done %b expected 11", {got, saw_done}); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    tests_run++;
    if (uart_data !== exp) begin fails++; $display("FAIL same_cycle_data: got %h expected %h", uart_data, exp); end
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (host_if.tx_done) begin done = 1'b1; break; end
    end
    tests_run++;
    if (!done) begin fails++; $display("FAIL same_cycle_tx_done: got 0 expected 1"); end
  endtask

  task automatic test_link_drop;
    bit seen, done;
    brk_len = 20;
    @(negedge clk); host_if.brk_req = 1'b1;
    @(negedge clk); host_if.brk_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (brk_busy) seen = 1'b1;
      else if (seen) break;
    end
    repeat (5) @(negedge clk);
    host_if.link_drop = 1'b1;
    @(negedge clk); host_if.link_drop = 1'b0;
    tests_run++;
    if (host_if.link_up !== 1'b0) begin fails++; $display("FAIL drop_in_guard: got %b expected 0", host_if.link_up); end
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (host_if.brk_done) begin done = 1'b1; break; end
    end
    tests_run++;
    if ({done, host_if.link_up} !== 2'b11) begin fails++; $display("FAIL guard_reasserts_link: got %b expected 11", {done, host_if.link_up}); end
    @(negedge clk); host_if.link_drop = 1'b1;
    @(negedge clk); host_if.link_drop = 1'b0;
    tests_run++;
    if ({host_if.link_up, host_if.tx_ready} !== 2'b00) begin
      fails++; $display("FAIL drop_in_idle: got %b expected 00", {host_if.link_up, host_if.tx_ready});
    end
  endtask

  task automatic test_timeout;
    int err_at;
    brk_respond = 1'b0;
    @(negedge clk); host_if.brk_req = 1'b1;
    @(negedge clk); host_if.brk_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (brk_start) break;
      @(negedge clk);
    end
    err_at = 0;
    for (int m = 1; m <= 20; m++) begin
      @(negedge clk);
      if (host_if.err) begin err_at = m; break; end
    end
    tests_run++;
    if (err_at != 9) begin fails++; $display("FAIL ack_timeout: got err at %0d expected 9", err_at); end
    tests_run++;
    if ({host_if.link_up, host_if.busy, updi_oe, updi_tx} !== 4'b0001) begin
      fails++; $display("FAIL timeout_state: got %b expected 0001", {host_if.link_up, host_if.busy, updi_oe, updi_tx});
    end
    @(negedge clk);
    tests_run++;
    if (host_if.err !== 1'b0) begin fails++; $display("FAIL err_width: got %b expected 0", host_if.err); end
    brk_respond = 1'b1;
  endtask

  task automatic test_no_link;
`ifdef UPDI_LINE_CTRL_AUTO_BREAK_EN
    bit saw_brk, got, done;
    logic [7:0] exp;
    brk_len = 20;
    @(negedge clk);
    host_if.tx_valid = 1'b1; host_if.tx_data = 8'h3C; exp_q.push_back(8'h3C);
    saw_brk = 1'b0; got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (brk_start) saw_brk = 1'b1;
      if (uart_start) begin got = 1'b1; break; end
    end
    host_if.tx_valid = 1'b0;
    tests_run++;
    if ({got, saw_brk} !== 2'b11) begin fails++; $display("FAIL auto_break: got start/brk %b expected 11", {got, saw_brk}); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    tests_run++;
    if (uart_data !== exp) begin fails++; $display("FAIL auto_break_data: got %h expected %h", uart_data, exp); end
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (host_if.tx_done) begin done = 1'b1; break; end
    end
    tests_run++;
    if (!done) begin fails++; $display("FAIL auto_break_tx_done: got 0 expected 1"); end
`else
    int bad;
    @(negedge clk);
    host_if.tx_valid = 1'b1; host_if.tx_data = 8'h3C;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (host_if.tx_ready !== 1'b0 || uart_start !== 1'b0 || host_if.busy !== 1'b0) bad++;
    end
    host_if.tx_valid = 1'b0;
    tests_run++;
    if (bad != 0) begin fails++; $display("FAIL no_link_blocks_tx: got %0d active cycles expected 0", bad); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    logic [7:0] exp;
    bit done, got;
    bytes[0] = 8'h01; bytes[1] = 8'hFE; bytes[2] = 8'h5A;
    brk_len = 20; uart_len = 10;
    @(negedge clk); host_if.brk_req = 1'b1;
    @(negedge clk); host_if.brk_req = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (host_if.brk_done) begin done = 1'b1; break; end
    end
    tests_run++;
    if ({done, host_if.link_up} !== 2'b11) begin fails++; $display("FAIL b2b_link: got %b expected 11", {done, host_if.link_up}); end
    for (int j = 0; j < 3; j++) begin
      host_if.tx_valid = 1'b1; host_if.tx_data = bytes[j]; exp_q.push_back(bytes[j]);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (uart_start) begin got = 1'b1; break; end
      end
      host_if.tx_valid = 1'b0;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      tests_run++;
      if (!got || uart_data !== exp) begin fails++; $display("FAIL b2b_byte%0d: got %h (start %b) expected %h", j, uart_data, got, exp); end
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (host_if.tx_done) break;
      end
    end
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] exp;
    bit got;
    uart_len = 50;
    @(negedge clk);
    host_if.tx_valid = 1'b1; host_if.tx_data = 8'hC7; exp_q.push_back(8'hC7);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_start) begin got = 1'b1; break; end
    end
    host_if.tx_valid = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    tests_run++;
    if (!got || uart_data !== exp) begin fails++; $display("FAIL rst_tx_data: got %h (start %b) expected %h", uart_data, got, exp); end
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({updi_tx, updi_oe, host_if.busy, host_if.link_up} !== 4'b1000) begin
      fails++; $display("FAIL async_reset_mid_tx: got %b expected 1000", {updi_tx, updi_oe, host_if.busy, host_if.link_up});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({host_if.tx_ready, host_if.busy, uart_data} !== 10'b0) begin
      fails++; $display("FAIL after_reset_release: got %b expected 0", {host_if.tx_ready, host_if.busy, uart_data});
    end
  endtask

  initial begin
    test_reset();
    test_break();
    test_tx_byte();
    test_brk_tx_same_cycle();
    test_link_drop();
    test_timeout();
    test_no_link();
    test_back_to_back();
    test_reset_mid_tx();
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_empty: got %0d left expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
